bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock and applies the per-digit +3 correction on every iteration.
- Feeds the seven-segment display path: takes a binary value from the counter/ALU side and returns packed BCD digits.
- Uses a start/ready/done handshake, so one small correction unit per digit is reused across WIDTH cycles instead of building a combinational tree.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion. Sampled only when ready=1.
- bin  input  WIDTH  binary operand. Captured on the accepted start cycle.
- ready  output  1  high in IDLE and DONE. Block can accept start.
- busy  output  1  high while converting (CONV state).
- done  output  1  one-cycle pulse when bcd is valid.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 (ones) is bits [3:0]. Held until the next accepted start.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high; rst is sampled on the rising edge of clk and overrides every other input.
- Reset values: state=IDLE, ready=1, busy=0, done=0, bcd=0. Internal shift register and bit counter are cleared.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - start=1 → load shift register {DIGITS*4 zeros, bin}, set counter=WIDTH, go to CONV.
  - start=0 → stay in IDLE.
- CONV, once per cycle:
  - Correct: every BCD digit field >= 5 gets +3, evaluated in parallel on the pre-shift value.
  - Shift: shift the whole register left by 1.
  - Counter: decrement.
  - Exit: when counter reaches 1 on the current cycle, transition to DONE. Exactly WIDTH CONV cycles occur.
- DONE:
  - bcd <= upper 4*DIGITS bits of the register; done=1 for this cycle only.
  - start=1 → accepted exactly as in IDLE, allowing back-to-back conversions.
  - start=0 → go to IDLE.
- Latency: start accepted at edge N → done=1 and bcd valid in cycle N+WIDTH+1. Default WIDTH=8 gives 9 cycles.
- Throughput: one conversion per WIDTH+1 cycles.
- start during CONV: ignored, and bin is not re-sampled.
- bcd stability: bcd updates only on entering DONE and keeps the previous result during CONV.
- Reset mid-CONV: abort immediately, return to reset values, discard the partial result.
- Arithmetic: digit correction is 4-bit. The DIGITS constraint guarantees no digit ever exceeds 9 after the final shift, so no overflow output exists.
- Boundary inputs: bin=0 → bcd=0. bin=2^WIDTH-1 → correct maximum value, e.g. 255 → 0x255.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Adds output port blank (width DIGITS), registered alongside bcd.
  - blank[i]=1 when digit i and all more-significant digits are zero, except digit 0, which is never blanked.
  - Reset value is all zeros.
  - Used by the display driver to suppress leading zeros.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (bcd_pkg include file):
  - state encodings: IDLE=2'd0, CONV=2'd1, DONE=2'd2.
  - BCD digit width constant, 4.
  - a digit-count helper function used for the DIGITS check.
- Sub-module: bcd_digit_adj, a 4-bit combinational unit (in >= 5 ? in+3 : in), instantiated DIGITS times by a generate loop.
- FSM, counter and shift register live in bin2bcd_seq.

Test Plan:
- Reset then bin=8'd0, start pulse → done exactly 9 cycles later, bcd=12'h000; ready=1 and busy=0 afterwards.
- bin=8'd255 → bcd=12'h255. Then bin=8'd99 → bcd=12'h099; with BIN2BCD_BLANK_EN, blank=3'b100.
- start held high with bin=8'd128, and bin changed to 8'd7 during CONV → result stays 12'h128, no extra done pulse; a new conversion starts in the DONE cycle because start is still high.
- Back-to-back: start in the DONE cycle with bin=8'd42 → second done 9 cycles after the first, bcd=12'h042, and bcd held 12'h<first> in between.
- rst asserted at CONV cycle 4 of bin=8'd200 → next cycle ready=1, busy=0, done=0, bcd=0; a following start with 8'd200 → 12'h200.
- WIDTH=12, DIGITS=4, bin=12'd4095 → bcd=16'h4095 after 13 cycles. Exhaustive sweep 0..255 at default against a reference model.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encodings, digit width and the digit-count helper used for the DIGITS check.
package bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Smallest digit count d with 10^d > 2^w - 1.
  function automatic int digits_for(input int w);
    longint unsigned maxv;
    longint unsigned p;
    int d;
    maxv = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    p = 64'd10;
    d = 1;
    for (int i = 0; i < 19; i++) begin
      if (p <= maxv) begin
        d++;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]       blank
`endif
);

  localparam int BW = BCD_W * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < digits_for(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sreg;
  logic [SW-1:0] sreg_nxt;
  logic [BW-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (sreg[WIDTH + g*BCD_W +: BCD_W]),
      .adj   (adj[g*BCD_W +: BCD_W])
    );
  end

  // Correction applies to the pre-shift digits, then the whole register shifts.
  assign sreg_nxt = {adj, sreg[WIDTH-1:0]} << 1;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CONV);
  assign done  = (state == DONE);

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              lead_zero;

  // Digit 0 is never blanked, so the scan stops at digit 1.
  always_comb begin
    blank_nxt = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero    = lead_zero && (sreg_nxt[WIDTH + i*BCD_W +: BCD_W] == 4'd0);
      blank_nxt[i] = lead_zero;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      bcd   <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sreg  <= {{BW{1'b0}}, bin};
            cnt   <= CW'(WIDTH);
            state <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          sreg <= sreg_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bcd   <= sreg_nxt[SW-1 -: BW];
`ifdef BIN2BCD_BLANK_EN
            blank <= blank_nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: drivers push expected results, monitors pop on done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [7:0]  bin = '0;
  logic [11:0] bin2 = '0;
  logic        ready, busy, done, ready2, busy2, done2;
  logic [11:0] bcd;
  logic [15:0] bcd2;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank;
  logic [3:0]  blank2;
`endif

  bin2bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank)
`endif
  );

  bin2bcd_seq #(.WIDTH(12), .DIGITS(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .ready(ready2), .busy(busy2), .done(done2), .bcd(bcd2)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, leading-zero blanking from the digits.
  function automatic exp_t model(input int v, input int ndig, input int lat);
    exp_t e;
    int   x;
    logic lz;
    e.bcd = '0;
    e.blank = '0;
    x = v;
    for (int i = 0; i < ndig; i++) begin
      e.bcd[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    lz = 1'b1;
    for (int i = ndig - 1; i >= 1; i--) begin
      lz = lz && (e.bcd[i*4 +: 4] == 4'd0);
      e.blank[i] = lz;
    end
    e.cyc = cyc + lat + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done bcd=%h at cyc %0d, none expected", bcd, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd[11:0]));
        check("latency", 32'(cyc), 32'(e.cyc));
`ifdef BIN2BCD_BLANK_EN
        check("blank", 32'(blank), 32'(e.blank[2:0]));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done2 bcd2=%h at cyc %0d, none expected", bcd2, cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("bcd2", 32'(bcd2), 32'(e.bcd));
        check("latency2", 32'(cyc), 32'(e.cyc));
`ifdef BIN2BCD_BLANK_EN
        check("blank2", 32'(blank2), 32'(e.blank));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 60) begin @(negedge clk); n++; end
    check("drain_timeout", 32'(q.size() + q2.size()), 32'd0);
  endtask

  // Start one conversion with a hand-computed expected BCD value.
  task automatic conv(input logic [7:0] v, input logic [11:0] want);
    exp_t e;
    wait_ready();
    e = model(int'(v), 3, 8);
    e.bcd = {4'd0, want};
    bin = v; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    conv(8'd0, 12'h000);
    drain();
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_busy",  32'(busy),  32'd0);

    conv(8'd255, 12'h255);
    conv(8'd99,  12'h099);
    drain();

    // start held through CONV: bin changes are ignored, DONE re-accepts.
    begin
      exp_t e;
      int k;
      k = cyc;
      e = model(128, 3, 8); e.bcd = 16'h0128;
      bin = 8'd128; start = 1'b1; q.push_back(e);
      @(negedge clk);
      bin = 8'd7;
      check("conv_busy",  32'(busy),  32'd1);
      check("conv_ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clk);
      check("conv_hold_bcd",  32'(bcd),  32'h099);
      check("conv_no_done",   32'(done), 32'd0);
      while (cyc < k + 8) @(negedge clk);
      bin = 8'd42;
      e = model(42, 3, 8); e.bcd = 16'h0042; e.cyc = k + 18;
      q.push_back(e);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_hold_bcd", 32'(bcd), 32'h128);
      drain();
    end

    // Reset during CONV cycle 4 discards the partial conversion.
    wait_ready();
    bin = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_bcd",   32'(bcd),   32'd0);
`ifdef BIN2BCD_BLANK_EN
    check("mid_rst_blank", 32'(blank), 32'd0);
`endif
    conv(8'd200, 12'h200);
    drain();

    // Wide instance: 12-bit input, 4 digits, 13-cycle latency.
    begin
      exp_t e;
      e = model(4095, 4, 12); e.bcd = 16'h4095;
      bin2 = 12'd4095; start2 = 1'b1; q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      drain();
      e = model(1000, 4, 12); e.bcd = 16'h1000;
      bin2 = 12'd1000; start2 = 1'b1; q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      drain();
    end

    // Sweep against the division model, back-to-back from DONE.
    for (int v = 0; v < 256; v++) begin
      exp_t e;
      wait_ready();
      e = model(v, 3, 8);
      bin = 8'(v); start = 1'b1; q.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
